// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: tap positions, the one-step generator function and
// the checker state encoding, used by both the generator and the checker.
package lfsr_pkg;

   localparam int unsigned LFSR_W = 128;
   localparam int unsigned TAP0   = 127;
   localparam int unsigned TAP1   = 51;
   localparam int unsigned TAP2   = 13;
   localparam int unsigned TAP3   = 8;
   localparam int unsigned TAP4   = 4;
   localparam int unsigned TAP5   = 1;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   // XNOR feedback: the all-ones word is the lock-up state and maps to itself.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
      return {x[LFSR_W-2:0],
              ~(x[TAP0] ^ x[TAP1] ^ x[TAP2] ^ x[TAP3] ^ x[TAP4] ^ x[TAP5])};
   endfunction

endpackage

// File: rtl/lfsr_128bit_checker.sv
// 128-bit LFSR stream checker: acquires a reference word, verifies LOCK_CNT
// consecutive steps, then tracks the stream and counts mismatches while locked.
module lfsr_128bit_checker
   import lfsr_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = 8,
   parameter int unsigned UNLOCK_ERR = 4,
   parameter int unsigned ERR_W      = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               valid_i,
   input  logic [127:0]       data_i,
   output logic               locked_o,
   output logic               err_o,
   output logic [ERR_W-1:0]   err_cnt_o,
   output logic [1:0]         state_o
);

   state_e             r_state, w_state_nxt;
   logic [127:0]       r_ref, w_ref_nxt;
   logic [127:0]       w_exp;
   logic [7:0]         r_match, w_match_nxt, w_match_inc;
   logic [7:0]         r_cerr, w_cerr_nxt, w_cerr_inc;
   logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_nxt;
   logic               r_err, w_err_nxt;
   logic               r_locked;
   logic               w_all_ones;
   logic               w_match;

   always_comb begin
      w_exp         = lfsr_next(r_ref);
      w_all_ones    = (data_i == '1);
      w_match       = (data_i == w_exp);
      w_match_inc   = r_match + 8'd1;
      w_cerr_inc    = r_cerr + 8'd1;
      w_state_nxt   = r_state;
      w_ref_nxt     = r_ref;
      w_match_nxt   = r_match;
      w_cerr_nxt    = r_cerr;
      w_err_cnt_nxt = r_err_cnt;
      w_err_nxt     = 1'b0;

      if (clear_i) begin
         w_state_nxt   = ST_SEARCH;
         w_match_nxt   = '0;
         w_cerr_nxt    = '0;
         w_err_cnt_nxt = '0;
      end else if (valid_i) begin
         unique case (r_state)
            ST_SEARCH: begin
               if (!w_all_ones) begin
                  w_ref_nxt   = data_i;
                  w_match_nxt = '0;
                  w_state_nxt = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (w_all_ones) begin
                  w_match_nxt = '0;
                  w_state_nxt = ST_SEARCH;
               end else if (w_match) begin
                  w_ref_nxt   = data_i;
                  w_match_nxt = w_match_inc;
                  if (w_match_inc == 8'(LOCK_CNT)) begin
                     w_state_nxt = ST_LOCKED;
                     w_cerr_nxt  = '0;
                  end
               end else begin
                  w_ref_nxt   = data_i;
                  w_match_nxt = '0;
               end
            end
            ST_LOCKED: begin
               if (w_match) begin
                  w_ref_nxt  = data_i;
                  w_cerr_nxt = '0;
               end else begin
                  // Flywheel: advance on the predicted word, not the corrupted one.
                  w_ref_nxt  = w_exp;
                  w_err_nxt  = 1'b1;
                  w_cerr_nxt = w_cerr_inc;
                  if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
                  if (w_cerr_inc == 8'(UNLOCK_ERR)) begin
                     w_state_nxt = ST_SEARCH;
                     w_match_nxt = '0;
                     w_cerr_nxt  = '0;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_SEARCH;
               w_match_nxt = '0;
               w_cerr_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_SEARCH;
         r_ref     <= '0;
         r_match   <= '0;
         r_cerr    <= '0;
         r_err_cnt <= '0;
         r_err     <= 1'b0;
         r_locked  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ref     <= w_ref_nxt;
         r_match   <= w_match_nxt;
         r_cerr    <= w_cerr_nxt;
         r_err_cnt <= w_err_cnt_nxt;
         r_err     <= w_err_nxt;
         r_locked  <= (w_state_nxt == ST_LOCKED);
      end
   end

   assign locked_o  = r_locked;
   assign err_o     = r_err;
   assign err_cnt_o = r_err_cnt;
   assign state_o   = r_state;

endmodule

// File: tb/tb_lfsr_128bit_checker.sv
// Directed bench for lfsr_128bit_checker: default instance plus an ERR_W=2
// instance sharing the same stimulus, checked against hand-derived values.
module tb_lfsr_128bit_checker;
   import lfsr_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         clear_i;
   logic         valid_i;
   logic [127:0] data_i;

   logic         locked_o, err_o;
   logic [15:0]  err_cnt_o;
   logic [1:0]   state_o;
   logic         locked2_o, err2_o;
   logic [1:0]   err_cnt2_o;
   logic [1:0]   state2_o;

   logic [127:0] g;
   int unsigned  n_vec = 0;
   int unsigned  n_err = 0;
   int unsigned  pulses;

   always #5 clk_i = ~clk_i;

   lfsr_128bit_checker #(.LOCK_CNT(8), .UNLOCK_ERR(4), .ERR_W(16)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
      .data_i(data_i), .locked_o(locked_o), .err_o(err_o),
      .err_cnt_o(err_cnt_o), .state_o(state_o));

   lfsr_128bit_checker #(.LOCK_CNT(8), .UNLOCK_ERR(4), .ERR_W(2)) u_dut2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
      .data_i(data_i), .locked_o(locked2_o), .err_o(err2_o),
      .err_cnt_o(err_cnt2_o), .state_o(state2_o));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one valid beat; outputs are sampled 1 time unit after the edge.
   task automatic send(input logic [127:0] d);
      valid_i = 1'b1;
      data_i  = d;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic send_good();
      send(g);
      g = lfsr_next(g);
   endtask

   task automatic send_bad(input int unsigned bit_idx);
      logic [127:0] d;
      d = g;
      d[bit_idx] = ~d[bit_idx];
      send(d);
      g = lfsr_next(g);
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic clear_with_beat();
      clear_i = 1'b1;
      send(g);
      g = lfsr_next(g);
      clear_i = 1'b0;
   endtask

   task automatic lock_up();
      for (int i = 0; i < 9; i++) send_good();
   endtask

   initial begin
      logic [127:0] hand [7];
      hand[0] = 128'h0;  hand[1] = 128'h1;  hand[2] = 128'h3;  hand[3] = 128'h6;
      hand[4] = 128'hC;  hand[5] = 128'h19; hand[6] = 128'h32;

      rst_ni = 1'b0; clear_i = 1'b0; valid_i = 1'b0; data_i = '0;
      #12;
      chk("rst_locked", 128'(locked_o), 128'd0);
      chk("rst_err",    128'(err_o),    128'd0);
      chk("rst_cnt",    128'(err_cnt_o), 128'd0);
      chk("rst_state",  128'(state_o),  128'd0);
      rst_ni = 1'b1;
      idle(1);

      // generator stream from seed 0
      g = '0;
      for (int i = 0; i < 7; i++) begin
         chk("gen_word", g, hand[i]);
         g = lfsr_next(g);
      end

      // acquisition: capture + 8 matches
      g = '0;
      send_good();
      chk("acq_verify", 128'(state_o), 128'd1);
      for (int i = 0; i < 7; i++) send_good();
      chk("acq_not_yet", 128'(locked_o), 128'd0);
      send_good();
      chk("acq_locked", 128'(locked_o), 128'd1);
      chk("acq_state",  128'(state_o),  128'd2);
      chk("acq_cnt",    128'(err_cnt_o), 128'd0);

      // idle gaps inside a locked stream
      for (int i = 0; i < 20; i++) begin
         send_good();
         idle($urandom_range(0, 3));
      end
      chk("gap_locked", 128'(locked_o), 128'd1);
      chk("gap_cnt",    128'(err_cnt_o), 128'd0);

      // single flipped word, flywheel keeps lock
      send_bad(5);
      chk("flip_err",    128'(err_o),    128'd1);
      chk("flip_cnt",    128'(err_cnt_o), 128'd1);
      chk("flip_locked", 128'(locked_o), 128'd1);
      send_good();
      chk("flip_err_off", 128'(err_o), 128'd0);
      for (int i = 0; i < 5; i++) send_good();
      chk("flip_cnt_hold", 128'(err_cnt_o), 128'd1);
      chk("flip_state",    128'(state_o),   128'd2);

      // four consecutive errors drop lock
      clear_with_beat();
      chk("clr_cnt",   128'(err_cnt_o), 128'd0);
      chk("clr_state", 128'(state_o),   128'd0);
      lock_up();
      chk("relock0", 128'(locked_o), 128'd1);
      for (int i = 0; i < 3; i++) send_bad(100);
      chk("burst3_state", 128'(state_o), 128'd2);
      chk("burst3_err",   128'(err_o),   128'd1);
      send_bad(0);
      chk("burst4_cnt",    128'(err_cnt_o), 128'd4);
      chk("burst4_state",  128'(state_o),   128'd0);
      chk("burst4_locked", 128'(locked_o),  128'd0);
      for (int i = 0; i < 8; i++) send_good();
      chk("relock_early", 128'(locked_o), 128'd0);
      send_good();
      chk("relock_9", 128'(locked_o), 128'd1);

      // all-ones lock-up word never leaves SEARCH
      clear_with_beat();
      for (int i = 0; i < 4; i++) begin
         send('1);
         chk("ones_state", 128'(state_o), 128'd0);
      end

      // ERR_W=2 saturation with isolated errors
      clear_with_beat();
      lock_up();
      chk("sat_locked2", 128'(locked2_o), 128'd1);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         send_bad(i * 7);
         if (err2_o === 1'b1) pulses++;
         send_good();
         send_good();
      end
      chk("sat_pulses", 128'(pulses),    128'd5);
      chk("sat_cnt2",   128'(err_cnt2_o), 128'd3);
      chk("sat_cnt16",  128'(err_cnt_o),  128'd5);
      chk("sat_locked", 128'(locked2_o),  128'd1);
      clear_with_beat();
      chk("clr2_cnt",   128'(err_cnt2_o), 128'd0);
      chk("clr2_state", 128'(state2_o),   128'd0);
      chk("clr2_err",   128'(err2_o),     128'd0);

      // asynchronous reset mid-lock
      lock_up();
      send_bad(64);
      chk("pre_rst_err", 128'(err_o), 128'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_locked", 128'(locked_o), 128'd0);
      chk("arst_err",    128'(err_o),    128'd0);
      chk("arst_cnt",    128'(err_cnt_o), 128'd0);
      chk("arst_state",  128'(state_o),  128'd0);
      idle(1);
      rst_ni = 1'b1;
      idle(1);
      send_good();
      chk("post_rst_state",  128'(state_o),  128'd1);
      chk("post_rst_locked", 128'(locked_o), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
